// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: load/store funct3 encodings and the
// load/store unit state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit: store byte enables
// and replicated write data, load lane extraction and extension, and the
// misaligned / illegal-encoding flag.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        [2:0]  funct3,
  input  logic        [1:0]  addr_lo,
  input  logic               is_store,
  input  logic        [31:0] st_data,
  input  logic        [31:0] ld_word,
  output logic        [3:0]  be,
  output logic        [31:0] wdata,
  output logic        [31:0] ld_data,
  output logic               misalign
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = 8'(ld_word >> {addr_lo, 3'b000});
  assign half_s = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

  // Byte and half codes are shared by loads and stores; is_store picks the role.
  always_comb begin
    be       = 4'b1111;
    wdata    = st_data;
    ld_data  = ld_word;
    misalign = 1'b0;
    case (funct3)
      F3_LB: begin
        if (is_store) begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{st_data[7:0]}};
        end else begin
          ld_data = {{24{byte_s[7]}}, byte_s};
        end
      end
      F3_LH: begin
        misalign = addr_lo[0];
        if (is_store) begin
          be    = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{st_data[15:0]}};
        end else begin
          ld_data = {{16{half_s[15]}}, half_s};
        end
      end
      F3_LW: begin
        misalign = |addr_lo;
      end
      F3_LBU: begin
        misalign = is_store;
        ld_data  = {24'd0, byte_s};
      end
      F3_LHU: begin
        misalign = is_store | addr_lo[0];
        ld_data  = {16'd0, half_s};
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// M-stage load/store unit: issues one outstanding data-bus transaction per
// access, stalls the pipeline while it is in flight, and returns aligned load data.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] alu_o_M,
  input  logic [31:0] wr_data_M,
  input  logic        flush,
  output logic [31:0] rd_data_M,
  output logic        stall_mem,
  output logic        misalign_M,
  output logic        bus_err_M,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_err
);

  lsu_state_t  state, state_nxt;
  logic        access, is_idle, busy, start, tmo_hit, kill, kill_now;
  logic [2:0]  funct3_p1;
  logic [1:0]  off_p1;
  logic [7:0]  tmo_cnt;
  logic [2:0]  al_funct3;
  logic [1:0]  al_off;
  logic        al_store;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld_data;
  logic        al_mis;

  assign access   = (mem_rd_M | mem_wr_M) & ~flush;
  assign is_idle  = (state == IDLE);
  assign busy     = (state == REQ) | (state == WAIT);
  assign start    = is_idle & access & ~al_mis;
  assign tmo_hit  = busy & (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign kill_now = kill | flush;

  // In IDLE the aligner checks the live instruction; afterwards it decodes the latched one.
  assign al_funct3 = is_idle ? funct3_M      : funct3_p1;
  assign al_off    = is_idle ? alu_o_M[1:0]  : off_p1;
  assign al_store  = is_idle ? mem_wr_M      : dbus_we;

  lsu_align u_align (
    .funct3   (al_funct3),
    .addr_lo  (al_off),
    .is_store (al_store),
    .st_data  (wr_data_M),
    .ld_word  (dbus_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (al_ld_data),
    .misalign (al_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (tmo_hit)       state_nxt = DONE;
        else if (dbus_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (dbus_rvalid || tmo_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_mem  = start | busy;
    misalign_M = is_idle & access & al_mis;
  end

  // Request latch, kill flag, timeout counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      funct3_p1  <= '0;
      off_p1     <= '0;
      kill       <= 1'b0;
      tmo_cnt    <= '0;
      rd_data_M  <= '0;
      bus_err_M  <= 1'b0;
    end else begin
      dbus_req <= (state_nxt == REQ);
      if (start) begin
        dbus_addr  <= {alu_o_M[31:2], 2'b00};
        dbus_be    <= al_be;
        dbus_wdata <= al_wdata;
        dbus_we    <= mem_wr_M;
        funct3_p1  <= funct3_M;
        off_p1     <= alu_o_M[1:0];
      end
      if (state == DONE)     kill <= 1'b0;
      else if (busy & flush) kill <= 1'b1;
      tmo_cnt <= busy ? tmo_cnt + 8'd1 : 8'd0;
      if ((state == WAIT) && dbus_rvalid) begin
        rd_data_M <= (dbus_err | kill_now | dbus_we) ? 32'd0 : al_ld_data;
        bus_err_M <= dbus_err & ~kill_now;
      end else if (tmo_hit) begin
        rd_data_M <= 32'd0;
        bus_err_M <= ~kill_now;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage with a cycle-stepped data-bus responder.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_M, mem_wr_M, flush;
  logic [2:0]  funct3_M;
  logic [31:0] alu_o_M, wr_data_M;
  logic [31:0] rd_data_M;
  logic        stall_mem, misalign_M, bus_err_M;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid, dbus_err;
  logic [31:0] dbus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Snapshot of the request channel on its first REQ cycle
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_we;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M),
    .funct3_M(funct3_M), .alu_o_M(alu_o_M), .wr_data_M(wr_data_M), .flush(flush),
    .rd_data_M(rd_data_M), .stall_mem(stall_mem), .misalign_M(misalign_M),
    .bus_err_M(bus_err_M), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .dbus_err(dbus_err)
  );

  task automatic idle_inputs();
    mem_rd_M = 0; mem_wr_M = 0; flush = 0; funct3_M = 3'b000;
    alu_o_M = 0; wr_data_M = 0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0; dbus_err = 0;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    mem_rd_M = rd; mem_wr_M = wr; funct3_M = f3; alu_o_M = addr; wr_data_M = wd;
  endtask

  // Called at a negedge with the access already on the inputs; returns at
  // negedge+1 of the first non-stalled cycle (DONE when stalls > 0).
  task automatic bus_run(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                         input logic err, input logic flush_wait,
                         output int stalls, output int reqs, output logic stable,
                         output logic done);
    logic granted;
    int   wcnt;
    stalls = 0; reqs = 0; stable = 1; done = 0; granted = 0; wcnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (dbus_gnt) granted = 1;
      if (!stall_mem) begin
        done = (stalls > 0);
        dbus_gnt = 0; dbus_rvalid = 0; dbus_err = 0; flush = 0;
        break;
      end
      stalls++;
      if (dbus_req) begin
        if (reqs == 0) begin
          r_addr = dbus_addr; r_be = dbus_be; r_wdata = dbus_wdata; r_we = dbus_we;
        end else if (dbus_addr !== r_addr || dbus_be !== r_be || dbus_wdata !== r_wdata) begin
          stable = 0;
        end
        reqs++;
      end
      dbus_gnt = dbus_req && (reqs > gnt_dly);
      flush = flush_wait && granted && (wcnt == 0);
      dbus_rvalid = 0; dbus_err = 0;
      if (granted) begin
        if (wcnt >= rv_dly) begin
          dbus_rvalid = 1; dbus_rdata = rdata; dbus_err = err;
        end
        wcnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    n_tests++; if (dbus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dbus_req); end
    n_tests++; if ({dbus_addr, dbus_be, dbus_wdata, dbus_we} !== 69'd0) begin n_fail++; $display("FAIL reset_bus: addr %h be %b wdata %h we %b want all 0", dbus_addr, dbus_be, dbus_wdata, dbus_we); end
    n_tests++; if (rd_data_M !== 32'd0 || bus_err_M !== 1'b0) begin n_fail++; $display("FAIL reset_result: rd %h err %b want 0/0", rd_data_M, bus_err_M); end
    n_tests++; if (stall_mem !== 1'b0 || misalign_M !== 1'b0) begin n_fail++; $display("FAIL reset_stall: stall %b mis %b want 0/0", stall_mem, misalign_M); end
    @(negedge clk);
  endtask

  task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    int s, r; logic st, dn;
    set_op(1, 0, f3, addr, 32'h0);
    bus_run(0, 0, rdata, 0, 0, s, r, st, dn);
    n_tests++; if (dn !== 1'b1 || s != 3) begin n_fail++; $display("FAIL %s_stall: done %b stalls %0d want 1/3", name, dn, s); end
    n_tests++; if (rd_data_M !== exp || bus_err_M !== 1'b0) begin n_fail++; $display("FAIL %s_data: got %h err %b want %h err 0", name, rd_data_M, bus_err_M, exp); end
    n_tests++; if (r_addr !== {addr[31:2], 2'b00} || r_be !== 4'b1111 || r_we !== 1'b0) begin n_fail++; $display("FAIL %s_req: addr %h be %b we %b want %h 1111 0", name, r_addr, r_be, r_we, {addr[31:2], 2'b00}); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_loads();
    run_load("lb",  3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
    run_load("lh",  3'b001, 32'h0000_0102, 32'h8001_7FFF, 32'hFFFF_8001);
    run_load("lhu", 3'b101, 32'h0000_0106, 32'h8001_7FFF, 32'h0000_8001);
    run_load("lh0", 3'b001, 32'h0000_0100, 32'h8001_7FFF, 32'h0000_7FFF);
    run_load("lw",  3'b010, 32'h0000_0108, 32'h1234_5678, 32'h1234_5678);
  endtask

  task automatic run_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
    int s, r; logic st, dn;
    set_op(0, 1, f3, addr, wd);
    bus_run(0, 0, 32'hFFFF_FFFF, 0, 0, s, r, st, dn);
    n_tests++; if (dn !== 1'b1 || s != 3) begin n_fail++; $display("FAIL %s_stall: done %b stalls %0d want 1/3", name, dn, s); end
    n_tests++; if (r_addr !== {addr[31:2], 2'b00} || r_be !== exp_be || r_wdata !== exp_wd || r_we !== 1'b1) begin n_fail++; $display("FAIL %s_req: addr %h be %b wdata %h we %b want %h %b %h 1", name, r_addr, r_be, r_wdata, r_we, {addr[31:2], 2'b00}, exp_be, exp_wd); end
    n_tests++; if (rd_data_M !== 32'd0) begin n_fail++; $display("FAIL %s_rd: got %h want 0", name, rd_data_M); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_stores();
    run_store("sh", 3'b001, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    run_store("sb", 3'b000, 32'h0000_0501, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);
    run_store("sw", 3'b010, 32'h0000_0504, 32'hCAFE_0001, 4'b1111, 32'hCAFE_0001);
  endtask

  task automatic test_misalign();
    int req_seen;
    set_op(1, 0, 3'b010, 32'h0000_0301, 32'h0);
    #1;
    n_tests++; if (misalign_M !== 1'b1 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL lw_mis: mis %b stall %b want 1/0", misalign_M, stall_mem); end
    req_seen = 0;
    repeat (3) begin @(negedge clk); #1; if (dbus_req) req_seen++; end
    n_tests++; if (req_seen != 0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL lw_mis_noreq: req cycles %0d stall %b want 0/0", req_seen, stall_mem); end
    set_op(1, 0, 3'b011, 32'h0000_0300, 32'h0);
    #1;
    n_tests++; if (misalign_M !== 1'b1 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL f3_011: mis %b stall %b want 1/0", misalign_M, stall_mem); end
    set_op(0, 1, 3'b100, 32'h0000_0300, 32'h0);
    #1;
    n_tests++; if (misalign_M !== 1'b1 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL store_f3_100: mis %b stall %b want 1/0", misalign_M, stall_mem); end
    set_op(1, 0, 3'b010, 32'h0000_0300, 32'h0);
    flush = 1;
    #1;
    n_tests++; if (misalign_M !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL idle_flush: mis %b stall %b want 0/0", misalign_M, stall_mem); end
    @(negedge clk); #1;
    n_tests++; if (dbus_req !== 1'b0) begin n_fail++; $display("FAIL idle_flush_req: got %b want 0", dbus_req); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_gnt_delay();
    int s, r; logic st, dn;
    set_op(1, 0, 3'b010, 32'h0000_0400, 32'h0);
    bus_run(4, 0, 32'h1122_3344, 0, 0, s, r, st, dn);
    n_tests++; if (dn !== 1'b1 || r != 5 || s != 7) begin n_fail++; $display("FAIL gnt_dly_cycles: done %b req %0d stall %0d want 1/5/7", dn, r, s); end
    n_tests++; if (st !== 1'b1 || r_addr !== 32'h0000_0400) begin n_fail++; $display("FAIL gnt_dly_stable: stable %b addr %h want 1 00000400", st, r_addr); end
    n_tests++; if (rd_data_M !== 32'h1122_3344) begin n_fail++; $display("FAIL gnt_dly_data: got %h want 11223344", rd_data_M); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_bus_err();
    int s, r; logic st, dn;
    set_op(1, 0, 3'b010, 32'h0000_0410, 32'h0);
    bus_run(0, 2, 32'h7777_7777, 1, 0, s, r, st, dn);
    n_tests++; if (dn !== 1'b1 || bus_err_M !== 1'b1 || rd_data_M !== 32'd0) begin n_fail++; $display("FAIL bus_err: done %b err %b rd %h want 1 1 00000000", dn, bus_err_M, rd_data_M); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int s, r; logic st, dn;
    set_op(1, 0, 3'b010, 32'h0000_0420, 32'h0);
    bus_run(100, 0, 32'h0, 0, 0, s, r, st, dn);
    n_tests++; if (dn !== 1'b1 || r != 8 || s != 9) begin n_fail++; $display("FAIL timeout_cycles: done %b req %0d stall %0d want 1/8/9", dn, r, s); end
    n_tests++; if (bus_err_M !== 1'b1 || rd_data_M !== 32'd0 || dbus_req !== 1'b0) begin n_fail++; $display("FAIL timeout_result: err %b rd %h req %b want 1 0 0", bus_err_M, rd_data_M, dbus_req); end
    idle_inputs();
    @(negedge clk); #1;
    n_tests++; if (dbus_req !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL timeout_after: req %b stall %b want 0/0", dbus_req, stall_mem); end
  endtask

  task automatic test_flush_wait();
    int s, r; logic st, dn;
    @(negedge clk);
    set_op(1, 0, 3'b010, 32'h0000_0600, 32'h0);
    bus_run(0, 1, 32'hDEAD_BEEF, 0, 1, s, r, st, dn);
    n_tests++; if (dn !== 1'b1 || rd_data_M !== 32'd0 || bus_err_M !== 1'b0) begin n_fail++; $display("FAIL flush_wait: done %b rd %h err %b want 1 0 0", dn, rd_data_M, bus_err_M); end
    idle_inputs();
    @(negedge clk);
    run_load("after_kill", 3'b010, 32'h0000_0700, 32'hCAFE_F00D, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid();
    set_op(1, 0, 3'b010, 32'h0000_0800, 32'h0);
    @(negedge clk);
    dbus_gnt = 1;
    @(negedge clk);
    dbus_gnt = 0;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    dbus_rvalid = 1; dbus_rdata = 32'h5555_5555;
    #1;
    n_tests++; if (dbus_req !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL rst_mid: req %b stall %b want 0/0", dbus_req, stall_mem); end
    @(negedge clk);
    dbus_rvalid = 0;
    #1;
    n_tests++; if (rd_data_M !== 32'd0 || bus_err_M !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid: rd %h err %b stall %b want 0 0 0", rd_data_M, bus_err_M, stall_mem); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_gnt_delay();
    test_bus_err();
    test_timeout();
    test_flush_wait();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
